// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
//   state_e  : display controller states
//   HEX_SEG  : hex nibble -> active-low segments {g..a}
//   SSEG_OFF : all anodes/cathodes inactive
package sseg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned DIG_W  = 3;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    SHOW  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [DIGITS-1:0] SSEG_OFF = 8'hFF;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble : 4-bit hex value
//   seg_c  : segments {g..a}, active-low
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/sseg_scan_driver.sv
// Pops 32-bit words from the writeback buffer, holds each for a number of
// full scan frames and multiplexes it as eight hex digits onto the display.
//   clk, n_rst  : clock, async active-low reset
//   data_in     : buffer head word (valid with data_valid)
//   data_valid  : buffer non-empty
//   data_pop    : buffer advance strobe (combinational)
//   SSEG_AN     : active-low anode enables, bit 0 = rightmost digit
//   SSEG_CA     : active-low cathodes, bit 7 = decimal point, 6:0 = g..a
//   busy        : a word is inside its dwell period
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter logic [15:0] CLK_DIV     = 16'd50000,
  parameter logic [7:0]  DWELL_SCANS = 8'd250,
  parameter logic        BLANK_LZ    = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_pop,
  output logic [7:0]        SSEG_AN,
  output logic [7:0]        SSEG_CA,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [15:0]       tick_cnt_q, tick_cnt_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0] disp_q, disp_d;
  logic [7:0]        an_q, an_d;
  logic [7:0]        ca_q, ca_d;

  logic              tick_c;
  logic              frame_end_c;
  logic              dwell_end_c;
  logic              pop_c;
  logic [NIB_W-1:0]  nibble_c;
  logic [SEG_W-1:0]  seg_c;
  logic              lz_blank_c;

  // Prescaler / frame / dwell event decode
  always_comb begin
    tick_c      = (tick_cnt_q == CLK_DIV - 16'd1);
    frame_end_c = tick_c && (digit_q == DIG_W'(DIGITS - 1));
    dwell_end_c = (state_q == SHOW) && frame_end_c &&
                  (frame_cnt_q == DWELL_SCANS - 8'd1);
    pop_c       = data_valid && ((state_q != SHOW) || dwell_end_c);
  end

  // Next state: free-running scan counters, pop loads a fresh word
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    disp_d      = disp_q;
    tick_cnt_d  = tick_c ? 16'd0 : tick_cnt_q + 16'd1;
    digit_d     = tick_c ? digit_q + DIG_W'(1) : digit_q;

    if (pop_c) begin
      state_d     = SHOW;
      frame_cnt_d = 8'd0;
      disp_d      = data_in;
    end else begin
      case (state_q)
        SHOW: begin
          if (dwell_end_c) begin
            state_d = HOLD;
          end else if (frame_end_c) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Digit select; a digit is a leading zero when it and everything above it is zero
  always_comb begin
    nibble_c   = disp_q[{digit_q, 2'b00} +: NIB_W];
    lz_blank_c = BLANK_LZ && (digit_q != DIG_W'(0)) &&
                 ((disp_q >> {digit_q, 2'b00}) == '0);
  end

  hex_to_sseg u_hex_to_sseg (
    .nibble (nibble_c),
    .seg_c  (seg_c)
  );

  // Registered display drive
  always_comb begin
    an_d = SSEG_OFF;
    ca_d = SSEG_OFF;
    if (state_q != BLANK) begin
      an_d = ~(8'd1 << digit_q);
      if (!lz_blank_c) begin
        ca_d = {1'b1, seg_c};
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= BLANK;
      tick_cnt_q  <= 16'd0;
      digit_q     <= '0;
      frame_cnt_q <= 8'd0;
      disp_q      <= '0;
      an_q        <= SSEG_OFF;
      ca_q        <= SSEG_OFF;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      digit_q     <= digit_d;
      frame_cnt_q <= frame_cnt_d;
      disp_q      <= disp_d;
      an_q        <= an_d;
      ca_q        <= ca_d;
    end
  end

  assign data_pop = pop_c;
  assign SSEG_AN  = an_q;
  assign SSEG_CA  = ca_q;
  assign busy     = (state_q == SHOW);

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver (CLK_DIV=4, DWELL_SCANS=2).
// Two instances share inputs: one with leading-zero blanking, one without.
module tb_sseg_scan_driver;

  logic        clk;
  logic        n_rst;
  logic [31:0] data_in;
  logic        data_valid;

  logic       pop_a, busy_a, pop_b, busy_b;
  logic [7:0] an_a, ca_a, an_b, ca_b;

  int errors = 0;
  int checks = 0;
  int m;  // edges since reset release

  typedef struct {
    logic [31:0] data;
    logic [63:0] ca_lz;   // {digit7 .. digit0} cathodes, blanking on
    logic [63:0] ca_nlz;  // same, blanking off
  } vec_t;

  vec_t vecs [8];

  sseg_scan_driver #(.CLK_DIV(16'd4), .DWELL_SCANS(8'd2), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
    .data_pop(pop_a), .SSEG_AN(an_a), .SSEG_CA(ca_a), .busy(busy_a)
  );

  sseg_scan_driver #(.CLK_DIV(16'd4), .DWELL_SCANS(8'd2), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
    .data_pop(pop_b), .SSEG_AN(an_b), .SSEG_CA(ca_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) m <= 0;
    else        m <= m + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Display dark, no pop, not busy, for n cycles
  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_an_a", 64'(an_a), 64'hFF);
      chk("idle_ca_a", 64'(ca_a), 64'hFF);
      chk("idle_an_b", 64'(an_b), 64'hFF);
      chk("idle_ca_b", 64'(ca_b), 64'hFF);
      chk("idle_pop",  64'(pop_a | pop_b), 64'd0);
      chk("idle_busy", 64'(busy_a | busy_b), 64'd0);
    end
  endtask

  // Anode/cathode pattern against the free-running digit model
  task automatic check_scan(input logic [63:0] exp_lz, input logic [63:0] exp_nlz, input int n);
    int d;
    logic [7:0] exp_an;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d      = ((m - 1) / 4) % 8;
      exp_an = ~(8'd1 << d);
      chk("scan_an_a", 64'(an_a), 64'(exp_an));
      chk("scan_an_b", 64'(an_b), 64'(exp_an));
      chk("scan_ca_a", 64'(ca_a), 64'(exp_lz[8*d +: 8]));
      chk("scan_ca_b", 64'(ca_b), 64'(exp_nlz[8*d +: 8]));
    end
    chk("scan_no_pop", 64'(pop_a), 64'd0);
  endtask

  // Present one word for one cycle; p returns the edge index that captured it
  task automatic do_pop(input logic [31:0] w, output int p);
    data_in    = w;
    data_valid = 1'b1;
    #1;
    chk("pop_a", 64'(pop_a), 64'd1);
    chk("pop_b", 64'(pop_b), 64'd1);
    @(negedge clk);
    p          = m;
    data_valid = 1'b0;
    #1;
    chk("busy_after_pop", 64'(busy_a), 64'd1);
    chk("pop_drop", 64'(pop_a), 64'd0);
  endtask

  // Dwell ends on the second frame end strictly after the pop edge
  task automatic wait_dwell(input int p);
    int n = 0;
    int exp_n;
    exp_n = (p / 32 + 1) * 32 + 32 - p;
    while (busy_a === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("dwell_len", 64'(n), 64'(exp_n));
    chk("hold_busy_b", 64'(busy_b), 64'd0);
    chk("hold_no_pop", 64'(pop_a), 64'd0);
  endtask

  initial begin
    int p, p1, p2, n;

    vecs[0] = '{32'h0000_00A5, 64'hFFFF_FFFF_FFFF_8892, 64'hC0C0_C0C0_C0C0_8892};
    vecs[1] = '{32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFC0, 64'hC0C0_C0C0_C0C0_C0C0};
    vecs[2] = '{32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFF9, 64'hC0C0_C0C0_C0C0_C0F9};
    vecs[3] = '{32'h1234_5678, 64'hF9A4_B099_9282_F880, 64'hF9A4_B099_9282_F880};
    vecs[4] = '{32'hFFFF_FFFF, 64'h8E8E_8E8E_8E8E_8E8E, 64'h8E8E_8E8E_8E8E_8E8E};
    vecs[5] = '{32'h00F0_0B00, 64'hFFFF_8EC0_C083_C0C0, 64'hC0C0_8EC0_C083_C0C0};
    vecs[6] = '{32'h0000_C0DE, 64'hFFFF_FFFF_C6C0_A186, 64'hC0C0_C0C0_C6C0_A186};
    vecs[7] = '{32'h9000_0000, 64'h90C0_C0C0_C0C0_C0C0, 64'h90C0_C0C0_C0C0_C0C0};

    n_rst      = 1'b0;
    data_valid = 1'b0;
    data_in    = 32'h0;

    // Reset held 5 cycles, then idle with no data
    repeat (5) @(negedge clk);
    chk("rst_an_a", 64'(an_a), 64'hFF);
    chk("rst_ca_a", 64'(ca_a), 64'hFF);
    chk("rst_pop",  64'(pop_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    n_rst = 1'b1;
    check_idle(10);

    // Table: load from BLANK/HOLD, measure dwell, then scan the held word
    for (int v = 0; v < 8; v++) begin
      do_pop(vecs[v].data, p);
      wait_dwell(p);
      check_scan(vecs[v].ca_lz, vecs[v].ca_nlz, 32);
    end

    // Back-to-back: second pop lands exactly on the dwell boundary
    data_in    = 32'h1234_5678;
    data_valid = 1'b1;
    #1;
    chk("b2b_pop1", 64'(pop_a), 64'd1);
    p1 = m + 1;
    @(negedge clk);
    data_in = 32'hFFFF_FFFF;
    #1;
    chk("b2b_no_consec", 64'(pop_a), 64'd0);
    chk("b2b_busy", 64'(busy_a), 64'd1);
    n = 0;
    while (pop_a !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    p2 = m + 1;
    chk("b2b_gap", 64'(p2 - p1), 64'((p1 / 32 + 2) * 32 - p1));
    @(negedge clk);
    p          = m;
    data_valid = 1'b0;
    #1;
    chk("b2b_busy2", 64'(busy_a), 64'd1);
    wait_dwell(p);
    check_scan(vecs[4].ca_lz, vecs[4].ca_nlz, 32);

    // Reset 20 cycles into a dwell
    do_pop(32'h0000_ABCD, p);
    repeat (19) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_an", 64'(an_a), 64'hFF);
    chk("mid_rst_ca", 64'(ca_a), 64'hFF);
    chk("mid_rst_busy", 64'(busy_a), 64'd0);
    chk("mid_rst_pop", 64'(pop_a), 64'd0);
    repeat (5) @(negedge clk);
    n_rst = 1'b1;
    check_idle(40);

    // Fresh word after the reset
    do_pop(32'h0000_0042, p);
    @(negedge clk);
    check_scan(64'hFFFF_FFFF_FFFF_99A4, 64'hC0C0_C0C0_C0C0_99A4, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
